// File: rtl/alu_issue_scheduler_if.sv
// rtl/alu_issue_scheduler_if.sv - dispatch, broadcast and ALU issue signal bundle
interface alu_issue_scheduler_if #(
  parameter int CSU_SIZE_BITS = 4
);
  logic                     disp_valid;
  logic [CSU_SIZE_BITS-1:0] disp_ins_id;
  logic                     disp_rs1_rdy;
  logic [31:0]              disp_rs1_val;
  logic [CSU_SIZE_BITS-1:0] disp_rs1_tag;
  logic                     disp_rs2_rdy;
  logic [31:0]              disp_rs2_val;
  logic [CSU_SIZE_BITS-1:0] disp_rs2_tag;
  logic [31:0]              disp_imm;
  logic [5:0]               disp_shamt;
  logic [6:0]               disp_opcode;
  logic [2:0]               disp_funct3;
  logic [6:0]               disp_funct7;
  logic [31:0]              disp_pc;
  logic                     disp_is_compressed;
  logic                     rs_full;

  logic                     cdb0_valid;
  logic [CSU_SIZE_BITS-1:0] cdb0_id;
  logic [31:0]              cdb0_val;
  logic                     cdb1_valid;
  logic [CSU_SIZE_BITS-1:0] cdb1_id;
  logic [31:0]              cdb1_val;

  logic                     have_ins;
  logic [CSU_SIZE_BITS-1:0] ins_id;
  logic [31:0]              rs1_val;
  logic [31:0]              rs2_val;
  logic [31:0]              imm_val;
  logic [5:0]               shamt_val;
  logic [6:0]               opcode;
  logic [2:0]               funct3;
  logic [6:0]               funct7;
  logic [31:0]              request_PC;
  logic                     is_compressed_ins;

  modport master (
    output disp_valid, disp_ins_id, disp_rs1_rdy, disp_rs1_val, disp_rs1_tag,
           disp_rs2_rdy, disp_rs2_val, disp_rs2_tag, disp_imm, disp_shamt,
           disp_opcode, disp_funct3, disp_funct7, disp_pc, disp_is_compressed,
           cdb0_valid, cdb0_id, cdb0_val, cdb1_valid, cdb1_id, cdb1_val,
    input  rs_full, have_ins, ins_id, rs1_val, rs2_val, imm_val, shamt_val,
           opcode, funct3, funct7, request_PC, is_compressed_ins
  );

  modport slave (
    input  disp_valid, disp_ins_id, disp_rs1_rdy, disp_rs1_val, disp_rs1_tag,
           disp_rs2_rdy, disp_rs2_val, disp_rs2_tag, disp_imm, disp_shamt,
           disp_opcode, disp_funct3, disp_funct7, disp_pc, disp_is_compressed,
           cdb0_valid, cdb0_id, cdb0_val, cdb1_valid, cdb1_id, cdb1_val,
    output rs_full, have_ins, ins_id, rs1_val, rs2_val, imm_val, shamt_val,
           opcode, funct3, funct7, request_PC, is_compressed_ins
  );
endinterface

// File: rtl/alu_issue_scheduler.sv
// rtl/alu_issue_scheduler.sv - ALU reservation station with CDB wake-up and in-order-by-slot issue
// Optional performance counters are enabled with `define ALU_ISSUE_SCHED_PERF_EN.
module alu_issue_scheduler #(
  parameter int RS_SIZE_BITS  = 3,
  parameter int CSU_SIZE_BITS = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  input  logic flush_pipline,
  alu_issue_scheduler_if.slave io
`ifdef ALU_ISSUE_SCHED_PERF_EN
  ,
  output logic [31:0] perf_issue_cnt,
  output logic [31:0] perf_full_stall_cnt,
  output logic [31:0] perf_wait_cnt
`endif
);

  localparam int RS_SIZE = 1 << RS_SIZE_BITS;

  typedef struct packed {
    logic                     valid;
    logic                     rs1_rdy;
    logic [31:0]              rs1_val;
    logic [CSU_SIZE_BITS-1:0] rs1_tag;
    logic                     rs2_rdy;
    logic [31:0]              rs2_val;
    logic [CSU_SIZE_BITS-1:0] rs2_tag;
    logic [CSU_SIZE_BITS-1:0] ins_id;
    logic [31:0]              imm;
    logic [5:0]               shamt;
    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic [6:0]               funct7;
    logic [31:0]              pc;
    logic                     is_c;
  } entry_t;

  typedef struct packed {
    logic                     have_ins;
    logic [CSU_SIZE_BITS-1:0] ins_id;
    logic [31:0]              rs1_val;
    logic [31:0]              rs2_val;
    logic [31:0]              imm;
    logic [5:0]               shamt;
    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic [6:0]               funct7;
    logic [31:0]              pc;
    logic                     is_c;
  } issue_t;

  entry_t ent_q [RS_SIZE];
  entry_t ent_d [RS_SIZE];
  issue_t iss_q;
  issue_t iss_d;

  logic [RS_SIZE-1:0]      valid_vec;
  logic [RS_SIZE-1:0]      elig_vec;
  logic                    sel_found;
  logic [RS_SIZE_BITS-1:0] sel_idx;
  logic                    free_found;
  logic [RS_SIZE_BITS-1:0] free_idx;
  logic                    rs_full;

  // Eligibility uses registered rdy bits only, so a wake-up can never issue in its own cycle.
  always_comb begin
    valid_vec  = '0;
    elig_vec   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      valid_vec[i] = ent_q[i].valid;
      elig_vec[i]  = ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy;
    end
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (elig_vec[i]) begin
        sel_found = 1'b1;
        sel_idx   = i[RS_SIZE_BITS-1:0];
      end
      if (!valid_vec[i]) begin
        free_found = 1'b1;
        free_idx   = i[RS_SIZE_BITS-1:0];
      end
    end
  end

  assign rs_full = &valid_vec;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];
    end
    iss_d = iss_q;

    if (rdy_in) begin
      iss_d.have_ins = 1'b0;
      if (flush_pipline) begin
        for (int i = 0; i < RS_SIZE; i++) begin
          ent_d[i].valid = 1'b0;
        end
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (ent_q[i].valid && !ent_q[i].rs1_rdy) begin
            if (io.cdb0_valid && io.cdb0_id == ent_q[i].rs1_tag) begin
              ent_d[i].rs1_rdy = 1'b1;
              ent_d[i].rs1_val = io.cdb0_val;
            end else if (io.cdb1_valid && io.cdb1_id == ent_q[i].rs1_tag) begin
              ent_d[i].rs1_rdy = 1'b1;
              ent_d[i].rs1_val = io.cdb1_val;
            end
          end
          if (ent_q[i].valid && !ent_q[i].rs2_rdy) begin
            if (io.cdb0_valid && io.cdb0_id == ent_q[i].rs2_tag) begin
              ent_d[i].rs2_rdy = 1'b1;
              ent_d[i].rs2_val = io.cdb0_val;
            end else if (io.cdb1_valid && io.cdb1_id == ent_q[i].rs2_tag) begin
              ent_d[i].rs2_rdy = 1'b1;
              ent_d[i].rs2_val = io.cdb1_val;
            end
          end
        end

        if (sel_found) begin
          iss_d.have_ins = 1'b1;
          iss_d.ins_id   = ent_q[sel_idx].ins_id;
          iss_d.rs1_val  = ent_q[sel_idx].rs1_val;
          iss_d.rs2_val  = ent_q[sel_idx].rs2_val;
          iss_d.imm      = ent_q[sel_idx].imm;
          iss_d.shamt    = ent_q[sel_idx].shamt;
          iss_d.opcode   = ent_q[sel_idx].opcode;
          iss_d.funct3   = ent_q[sel_idx].funct3;
          iss_d.funct7   = ent_q[sel_idx].funct7;
          iss_d.pc       = ent_q[sel_idx].pc;
          iss_d.is_c     = ent_q[sel_idx].is_c;
          ent_d[sel_idx].valid = 1'b0;
        end

        // The free slot comes from registered valids, so it never collides with the issuing slot.
        if (io.disp_valid && free_found) begin
          ent_d[free_idx].valid   = 1'b1;
          ent_d[free_idx].ins_id  = io.disp_ins_id;
          ent_d[free_idx].rs1_tag = io.disp_rs1_tag;
          ent_d[free_idx].rs2_tag = io.disp_rs2_tag;
          ent_d[free_idx].imm     = io.disp_imm;
          ent_d[free_idx].shamt   = io.disp_shamt;
          ent_d[free_idx].opcode  = io.disp_opcode;
          ent_d[free_idx].funct3  = io.disp_funct3;
          ent_d[free_idx].funct7  = io.disp_funct7;
          ent_d[free_idx].pc      = io.disp_pc;
          ent_d[free_idx].is_c    = io.disp_is_compressed;
          ent_d[free_idx].rs1_rdy = io.disp_rs1_rdy;
          ent_d[free_idx].rs1_val = io.disp_rs1_val;
          ent_d[free_idx].rs2_rdy = io.disp_rs2_rdy;
          ent_d[free_idx].rs2_val = io.disp_rs2_val;
          if (!io.disp_rs1_rdy) begin
            if (io.cdb0_valid && io.cdb0_id == io.disp_rs1_tag) begin
              ent_d[free_idx].rs1_rdy = 1'b1;
              ent_d[free_idx].rs1_val = io.cdb0_val;
            end else if (io.cdb1_valid && io.cdb1_id == io.disp_rs1_tag) begin
              ent_d[free_idx].rs1_rdy = 1'b1;
              ent_d[free_idx].rs1_val = io.cdb1_val;
            end
          end
          if (!io.disp_rs2_rdy) begin
            if (io.cdb0_valid && io.cdb0_id == io.disp_rs2_tag) begin
              ent_d[free_idx].rs2_rdy = 1'b1;
              ent_d[free_idx].rs2_val = io.cdb0_val;
            end else if (io.cdb1_valid && io.cdb1_id == io.disp_rs2_tag) begin
              ent_d[free_idx].rs2_rdy = 1'b1;
              ent_d[free_idx].rs2_val = io.cdb1_val;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= '0;
      end
      iss_q <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= ent_d[i];
      end
      iss_q <= iss_d;
    end
  end

  assign io.rs_full           = rs_full;
  assign io.have_ins          = iss_q.have_ins;
  assign io.ins_id            = iss_q.ins_id;
  assign io.rs1_val           = iss_q.rs1_val;
  assign io.rs2_val           = iss_q.rs2_val;
  assign io.imm_val           = iss_q.imm;
  assign io.shamt_val         = iss_q.shamt;
  assign io.opcode            = iss_q.opcode;
  assign io.funct3            = iss_q.funct3;
  assign io.funct7            = iss_q.funct7;
  assign io.request_PC        = iss_q.pc;
  assign io.is_compressed_ins = iss_q.is_c;

`ifdef ALU_ISSUE_SCHED_PERF_EN
  logic [31:0] perf_issue_q, perf_issue_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_wait_q,  perf_wait_d;

  // Counters survive flush; only reset clears them.
  always_comb begin
    perf_issue_d = perf_issue_q;
    perf_stall_d = perf_stall_q;
    perf_wait_d  = perf_wait_q;
    if (rdy_in) begin
      if (!flush_pipline && sel_found) perf_issue_d = perf_issue_q + 32'd1;
      if (io.disp_valid && rs_full)    perf_stall_d = perf_stall_q + 32'd1;
      if ((|valid_vec) && !sel_found)  perf_wait_d  = perf_wait_q + 32'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
      perf_wait_q  <= '0;
    end else begin
      perf_issue_q <= perf_issue_d;
      perf_stall_q <= perf_stall_d;
      perf_wait_q  <= perf_wait_d;
    end
  end

  assign perf_issue_cnt      = perf_issue_q;
  assign perf_full_stall_cnt = perf_stall_q;
  assign perf_wait_cnt       = perf_wait_q;
`endif

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// tb/tb_alu_issue_scheduler.sv - directed self-checking bench for alu_issue_scheduler
module tb_alu_issue_scheduler;
  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic flush_pipline;
  int   total = 0;
  int   bad   = 0;

  alu_issue_scheduler_if #(.CSU_SIZE_BITS(4)) bus ();

`ifdef ALU_ISSUE_SCHED_PERF_EN
  logic [31:0] perf_issue_cnt, perf_full_stall_cnt, perf_wait_cnt;
`endif

  alu_issue_scheduler #(.RS_SIZE_BITS(3), .CSU_SIZE_BITS(4)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .flush_pipline (flush_pipline),
    .io            (bus)
`ifdef ALU_ISSUE_SCHED_PERF_EN
    ,
    .perf_issue_cnt      (perf_issue_cnt),
    .perf_full_stall_cnt (perf_full_stall_cnt),
    .perf_wait_cnt       (perf_wait_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.disp_valid = 1'b0;
    bus.disp_ins_id = '0;
    bus.disp_rs1_rdy = 1'b0;
    bus.disp_rs1_val = '0;
    bus.disp_rs1_tag = '0;
    bus.disp_rs2_rdy = 1'b0;
    bus.disp_rs2_val = '0;
    bus.disp_rs2_tag = '0;
    bus.disp_imm = '0;
    bus.disp_shamt = '0;
    bus.disp_opcode = '0;
    bus.disp_funct3 = '0;
    bus.disp_funct7 = '0;
    bus.disp_pc = '0;
    bus.disp_is_compressed = 1'b0;
    bus.cdb0_valid = 1'b0;
    bus.cdb0_id = '0;
    bus.cdb0_val = '0;
    bus.cdb1_valid = 1'b0;
    bus.cdb1_id = '0;
    bus.cdb1_val = '0;
  endtask

  task automatic disp(input logic [3:0] id, input logic r1rdy, input logic [31:0] r1val,
                      input logic [3:0] r1tag, input logic r2rdy, input logic [31:0] r2val,
                      input logic [3:0] r2tag, input logic [31:0] imm, input logic [6:0] opc);
    bus.disp_valid   = 1'b1;
    bus.disp_ins_id  = id;
    bus.disp_rs1_rdy = r1rdy;
    bus.disp_rs1_val = r1val;
    bus.disp_rs1_tag = r1tag;
    bus.disp_rs2_rdy = r2rdy;
    bus.disp_rs2_val = r2val;
    bus.disp_rs2_tag = r2tag;
    bus.disp_imm     = imm;
    bus.disp_opcode  = opc;
    bus.disp_pc      = 32'h1000 + {28'd0, id};
  endtask

  initial begin
    idle_inputs();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    flush_pipline = 1'b0;
    tick();
    tick();
    rst_in = 1'b1;
    check("rst_have_ins", {31'd0, bus.have_ins}, 32'd0);
    check("rst_rs_full", {31'd0, bus.rs_full}, 32'd0);
    check("rst_ins_id", {28'd0, bus.ins_id}, 32'd0);
    check("rst_rs1_val", bus.rs1_val, 32'd0);

    // ready ADDI
    disp(4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd0, 4'd0, 32'd7, 7'b0010011);
    tick();
    idle_inputs();
    check("ready_not_yet", {31'd0, bus.have_ins}, 32'd0);
    tick();
    check("ready_have_ins", {31'd0, bus.have_ins}, 32'd1);
    check("ready_ins_id", {28'd0, bus.ins_id}, 32'd3);
    check("ready_rs1_val", bus.rs1_val, 32'd5);
    check("ready_imm", bus.imm_val, 32'd7);
    check("ready_opcode", {25'd0, bus.opcode}, 32'h13);
    check("ready_pc", bus.request_PC, 32'h1003);
    tick();
    check("ready_drop", {31'd0, bus.have_ins}, 32'd0);

    // wake-up through cdb1
    disp(4'd2, 1'b1, 32'd10, 4'd0, 1'b0, 32'd0, 4'd9, 32'd0, 7'b0110011);
    tick();
    idle_inputs();
    tick();
    tick();
    check("wake_pending", {31'd0, bus.have_ins}, 32'd0);
    bus.cdb1_valid = 1'b1;
    bus.cdb1_id = 4'd9;
    bus.cdb1_val = 32'h1234;
    tick();
    idle_inputs();
    check("wake_same_cycle", {31'd0, bus.have_ins}, 32'd0);
    tick();
    check("wake_have_ins", {31'd0, bus.have_ins}, 32'd1);
    check("wake_ins_id", {28'd0, bus.ins_id}, 32'd2);
    check("wake_rs2_val", bus.rs2_val, 32'h1234);
    check("wake_rs1_val", bus.rs1_val, 32'd10);

    // fill all eight entries
    for (int i = 0; i < 8; i++) begin
      disp(i[3:0], 1'b0, 32'd0, 4'd1, 1'b1, 32'd0, 4'd0, 32'd0, 7'b0110011);
      tick();
      if (i == 6) check("fill7_not_full", {31'd0, bus.rs_full}, 32'd0);
    end
    check("full_set", {31'd0, bus.rs_full}, 32'd1);
    disp(4'd15, 1'b1, 32'd99, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0, 7'b0110011);
    tick();
    idle_inputs();
    check("full_still", {31'd0, bus.rs_full}, 32'd1);
    check("full_no_issue", {31'd0, bus.have_ins}, 32'd0);
    bus.cdb0_valid = 1'b1;
    bus.cdb0_id = 4'd1;
    bus.cdb0_val = 32'd4;
    tick();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      tick();
      check("full_issue_have", {31'd0, bus.have_ins}, 32'd1);
      check("full_issue_id", {28'd0, bus.ins_id}, i);
      check("full_issue_rs1", bus.rs1_val, 32'd4);
    end
    check("full_cleared", {31'd0, bus.rs_full}, 32'd0);
    tick();
    check("full_no_ninth", {31'd0, bus.have_ins}, 32'd0);

    // same-cycle bypass, cdb0 beats cdb1
    disp(4'd5, 1'b0, 32'd0, 4'd6, 1'b1, 32'd0, 4'd0, 32'd0, 7'b0110011);
    bus.cdb0_valid = 1'b1;
    bus.cdb0_id = 4'd6;
    bus.cdb0_val = 32'hAA;
    bus.cdb1_valid = 1'b1;
    bus.cdb1_id = 4'd6;
    bus.cdb1_val = 32'hBB;
    tick();
    idle_inputs();
    tick();
    check("byp_have_ins", {31'd0, bus.have_ins}, 32'd1);
    check("byp_ins_id", {28'd0, bus.ins_id}, 32'd5);
    check("byp_rs1_val", bus.rs1_val, 32'hAA);

    // flush with three ready entries plus a dispatch
    for (int i = 10; i < 13; i++) begin
      disp(i[3:0], 1'b0, 32'd0, 4'd7, 1'b1, 32'd0, 4'd0, 32'd0, 7'b0110011);
      tick();
    end
    idle_inputs();
    bus.cdb0_valid = 1'b1;
    bus.cdb0_id = 4'd7;
    bus.cdb0_val = 32'd3;
    tick();
    idle_inputs();
    flush_pipline = 1'b1;
    disp(4'd13, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 32'd0, 7'b0110011);
    tick();
    idle_inputs();
    flush_pipline = 1'b0;
    check("flush_have_ins", {31'd0, bus.have_ins}, 32'd0);
    check("flush_rs_full", {31'd0, bus.rs_full}, 32'd0);
    check("flush_hold_id", {28'd0, bus.ins_id}, 32'd5);
    tick();
    check("flush_quiet1", {31'd0, bus.have_ins}, 32'd0);
    tick();
    check("flush_quiet2", {31'd0, bus.have_ins}, 32'd0);
    disp(4'd14, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 32'd0, 7'b0110011);
    tick();
    idle_inputs();
    tick();
    check("post_flush_have", {31'd0, bus.have_ins}, 32'd1);
    check("post_flush_id", {28'd0, bus.ins_id}, 32'd14);
    tick();

    // freeze with rdy_in low
    disp(4'd4, 1'b0, 32'd0, 4'd3, 1'b1, 32'd0, 4'd0, 32'd0, 7'b0110011);
    tick();
    disp(4'd8, 1'b1, 32'd8, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0, 7'b0110011);
    tick();
    idle_inputs();
    tick();
    check("frz_pre_have", {31'd0, bus.have_ins}, 32'd1);
    rdy_in = 1'b0;
    bus.cdb0_valid = 1'b1;
    bus.cdb0_id = 4'd3;
    bus.cdb0_val = 32'h55;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("frz_have", {31'd0, bus.have_ins}, 32'd1);
      check("frz_id", {28'd0, bus.ins_id}, 32'd8);
    end
    rdy_in = 1'b1;
    idle_inputs();
    tick();
    check("frz_lost1", {31'd0, bus.have_ins}, 32'd0);
    tick();
    check("frz_lost2", {31'd0, bus.have_ins}, 32'd0);

    // reset mid-operation
    disp(4'd9, 1'b1, 32'd9, 4'd0, 1'b1, 32'd0, 4'd0, 32'd0, 7'b0110011);
    tick();
    idle_inputs();
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    check("mrst_have_ins", {31'd0, bus.have_ins}, 32'd0);
    check("mrst_ins_id", {28'd0, bus.ins_id}, 32'd0);
    check("mrst_rs_full", {31'd0, bus.rs_full}, 32'd0);
    bus.cdb0_valid = 1'b1;
    bus.cdb0_id = 4'd3;
    bus.cdb0_val = 32'd1;
    tick();
    idle_inputs();
    tick();
    check("mrst_empty1", {31'd0, bus.have_ins}, 32'd0);
    tick();
    check("mrst_empty2", {31'd0, bus.have_ins}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
